// File: rtl/led_breathe.sv
// led_breathe: breathing-LED controller driving an active-low pin with glitch-free PWM.
// The brightness ramps up, holds, ramps down and holds on each tick, repeating indefinitely.
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int HOLD_TICKS = 16
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                enable,
  input  logic                tick,
  output logic                nLED,
  output logic [PWM_BITS-1:0] brightness,
  output logic [1:0]          phase,
  output logic                cycleDone
);
  typedef enum logic [1:0] {UP, HOLD_HIGH, DOWN, HOLD_LOW} state_t;
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] MAX_M1    = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
  localparam logic [15:0]         HOLD_LAST = 16'(HOLD_TICKS - 1);
  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d, duty_q, pwm_q;
  logic [15:0]         hold_q, hold_d;
  logic                nled_q, done_q, done_d;
  logic                step, hold_end;
  assign step     = enable & tick;
  assign hold_end = hold_q == HOLD_LAST;
  always_ff @(posedge clk) begin
    if (!nRst) state_q <= UP;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (step)
      unique case (state_q)
        UP:        state_d = level_q == MAX_M1 ? HOLD_HIGH : UP;
        HOLD_HIGH: state_d = hold_end ? DOWN : HOLD_HIGH;
        DOWN:      state_d = level_q == LVL_ONE ? HOLD_LOW : DOWN;
        HOLD_LOW:  state_d = hold_end ? UP : HOLD_LOW;
      endcase
  end
  // Boundary checks on the ramps keep level from ever wrapping.
  always_comb begin
    level_d = level_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (step)
      unique case (state_q)
        UP: begin
          level_d = level_q + 1'b1;
          hold_d  = level_q == MAX_M1 ? '0 : hold_q;
        end
        HOLD_HIGH: hold_d = hold_end ? hold_q : hold_q + 16'd1;
        DOWN: begin
          level_d = level_q - 1'b1;
          hold_d  = level_q == LVL_ONE ? '0 : hold_q;
        end
        HOLD_LOW: begin
          hold_d = hold_end ? hold_q : hold_q + 16'd1;
          done_d = hold_end;
        end
      endcase
  end
  // Duty is only reloaded on the wrap edge so a PWM period never changes mid-way.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      level_q <= '0;
      duty_q  <= '0;
      pwm_q   <= '0;
      hold_q  <= '0;
      nled_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      nled_q  <= enable ? ~(pwm_q < duty_q) : 1'b1;
      if (enable) begin
        pwm_q <= pwm_q + 1'b1;
        if (pwm_q == MAX) duty_q <= level_q;
      end
    end
  end
  assign nLED       = nled_q;
  assign brightness = level_q;
  assign phase      = state_q;
  assign cycleDone  = done_q;
endmodule

// File: tb/tb_led_breathe.sv
// tb_led_breathe: directed checks of ramp/hold sequencing, PWM shape, freeze and reset.
module tb_led_breathe;
  logic       clk = 1'b0;
  logic       nRst = 1'b0, enable = 1'b1, tick = 1'b0;
  logic       nLED, cycleDone;
  logic [2:0] brightness;
  logic [1:0] phase;
  logic       nRst_b = 1'b0, tick_b = 1'b0;
  logic       nLED_b, cycleDone_b;
  logic [7:0] brightness_b;
  logic [1:0] phase_b;
  logic [2:0] m_pwm = 3'd0;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  led_breathe #(.PWM_BITS(3), .HOLD_TICKS(2)) dut (
    .clk(clk), .nRst(nRst), .enable(enable), .tick(tick),
    .nLED(nLED), .brightness(brightness), .phase(phase), .cycleDone(cycleDone)
  );
  led_breathe dut_b (
    .clk(clk), .nRst(nRst_b), .enable(1'b1), .tick(tick_b),
    .nLED(nLED_b), .brightness(brightness_b), .phase(phase_b), .cycleDone(cycleDone_b)
  );
  // Free-running reference of the PWM counter position for the small instance.
  always @(posedge clk) m_pwm <= !nRst ? 3'd0 : (enable ? m_pwm + 3'd1 : m_pwm);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_tick();
    tick = 1'b1;
    wait_clks(1);
    tick = 1'b0;
  endtask
  task automatic pwm_chk(input string tag, input int duty, input int n);
    for (int i = 0; i < n; i++) begin
      logic [2:0] p;
      wait_clks(1);
      p = m_pwm - 3'd1;
      chk(tag, 32'(nLED), (32'(p) < 32'(duty)) ? 32'd0 : 32'd1);
    end
  endtask
  initial begin
    int b_exp[18] = '{1,2,3,4,5,6,7,7,7,6,5,4,3,2,1,0,0,0};
    int p_exp[18] = '{0,0,0,0,0,0,1,1,2,2,2,2,2,2,2,3,3,0};
    int lows, n, highs;
    bit found;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick = ~tick;
      wait_clks(1);
      chk("rst_nled", 32'(nLED), 32'd1);
      chk("rst_bright", 32'(brightness), 32'd0);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_done", 32'(cycleDone), 32'd0);
    end
    tick = 1'b0;
    nRst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_clks(1);
      chk("idle_nled", 32'(nLED), 32'd1);
    end
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 18; i++) begin
        do_tick();
        chk("cyc_bright", 32'(brightness), 32'(b_exp[i]));
        chk("cyc_phase", 32'(phase), 32'(p_exp[i]));
        chk("cyc_done", 32'(cycleDone), (i == 17) ? 32'd1 : 32'd0);
        wait_clks(1);
        chk("cyc_done_low", 32'(cycleDone), 32'd0);
        wait_clks(18);
      end
    repeat (3) do_tick();
    chk("lvl3_bright", 32'(brightness), 32'd3);
    wait_clks(8);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] p;
      wait_clks(1);
      p = m_pwm - 3'd1;
      if (!nLED) lows++;
      chk("duty3", 32'(nLED), (p < 3'd3) ? 32'd0 : 32'd1);
    end
    chk("duty3_lows", 32'(lows), 32'd6);
    nRst = 1'b0;
    wait_clks(1);
    nRst = 1'b1;
    repeat (2) do_tick();
    wait_clks(16);
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (m_pwm == 3'd0) found = 1;
      else wait_clks(1);
    end
    chk("align_pwm0", 32'(found), 32'd1);
    pwm_chk("glitch_old_lo", 2, 4);
    tick = 1'b1;
    wait_clks(1);
    tick = 1'b0;
    chk("glitch_step_nled", 32'(nLED), 32'd1);
    chk("glitch_step_bright", 32'(brightness), 32'd3);
    pwm_chk("glitch_old_hi", 2, 3);
    pwm_chk("glitch_new", 3, 8);
    nRst = 1'b0;
    wait_clks(1);
    nRst = 1'b1;
    repeat (11) do_tick();
    chk("frz_pre_bright", 32'(brightness), 32'd5);
    chk("frz_pre_phase", 32'(phase), 32'd2);
    wait_clks(16);
    wait_clks(3);
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick = ~tick;
      wait_clks(1);
      chk("frz_nled", 32'(nLED), 32'd1);
      chk("frz_bright", 32'(brightness), 32'd5);
    end
    chk("frz_phase", 32'(phase), 32'd2);
    chk("frz_done", 32'(cycleDone), 32'd0);
    tick = 1'b0;
    enable = 1'b1;
    pwm_chk("frz_resume_pwm", 5, 8);
    do_tick();
    chk("frz_resume_bright", 32'(brightness), 32'd4);
    chk("frz_resume_phase", 32'(phase), 32'd2);
    nRst_b = 1'b1;
    tick_b = 1'b1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      wait_clks(1);
      if (cycleDone_b) found = 1;
    end
    chk("def_first_done", 32'(found), 32'd1);
    found = 0;
    n = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      wait_clks(1);
      n++;
      if (cycleDone_b) found = 1;
    end
    chk("def_period", 32'(n), 32'd542);
    wait_clks(255);
    tick_b = 1'b0;
    chk("def_bright_max", 32'(brightness_b), 32'd255);
    chk("def_phase_hold", 32'(phase_b), 32'd1);
    wait_clks(512);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      wait_clks(1);
      if (nLED_b) highs++;
    end
    chk("def_max_off", 32'(highs), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/led_breathe.md
# led_breathe

Breathing-LED controller sitting directly downstream of `clkDivHz`. It consumes the single-cycle `dividedPulse` strobe as its brightness-step tick and drives the active-low `nLED` pin with glitch-free PWM. The brightness ramps up, holds, ramps down and holds, repeating indefinitely. It replaces the direct `nLED = dividedClk` hookup in board tops that want a fade instead of a hard blink.

## Interface
- `PWM_BITS`, 8: PWM counter and brightness width. MAX = 2^PWM_BITS-1. Legal range 2..16.
- `HOLD_TICKS`, 16: ticks spent in each hold phase. Legal range 1..65535. The hold counter is 16 bits.
- `clk`  input  1  system clock.
- `nRst`  input  1  synchronous, active-low reset, sampled on rising `clk`.
- `enable`  input  1  high = run. Low = freeze all state and force the LED off.
- `tick`  input  1  brightness-step strobe, one `clk` wide, from `clkDivHz.dividedPulse`.
- `nLED`  output  1  registered PWM output, active low.
- `brightness`  output  PWM_BITS  current level register.
- `phase`  output  2  0 = UP, 1 = HOLD_HIGH, 2 = DOWN, 3 = HOLD_LOW.
- `cycleDone`  output  1  one-`clk` pulse on each HOLD_LOW→UP transition.

## Operation
- Registers:
  - `level` (PWM_BITS)
  - `duty` (PWM_BITS)
  - `pwmCount` (PWM_BITS)
  - `holdCount` (16)
  - `state` (2)
  - `nLED`
  - `cycleDone`
- A step is a rising edge with `nRst=1`, `enable=1`, `tick=1`. State and `level` change only on steps.
- State machine:
  - UP: step → if `level == MAX-1`, set `level = MAX`, `holdCount = 0`, go to HOLD_HIGH; otherwise `level++`.
  - HOLD_HIGH: step → if `holdCount == HOLD_TICKS-1`, go to DOWN; otherwise `holdCount++`.
  - DOWN: step → if `level == 1`, set `level = 0`, `holdCount = 0`, go to HOLD_LOW; otherwise `level--`.
  - HOLD_LOW: step → if `holdCount == HOLD_TICKS-1`, go to UP and pulse `cycleDone`; otherwise `holdCount++`.
- `level` never wraps. The UP and DOWN boundary checks guarantee this.
- Period is 2·MAX + 2·HOLD_TICKS ticks. Defaults give 542 ticks.
- PWM:
  - `pwmCount` increments on every `clk` while `enable=1` and wraps from MAX to 0.
  - `duty` loads `level` only on the edge where `pwmCount == MAX`, so the duty cycle never changes mid-period.
- LED drive:
  - Each enabled edge: `nLED <= ~(pwmCount < duty)`.
  - Duty 0 gives constantly off. Duty MAX gives on for MAX of every 2^PWM_BITS clocks.
- `enable=0`: `level`, `duty`, `pwmCount`, `holdCount` and `state` hold their values, and `tick` is ignored. `nLED <= 1` and `cycleDone <= 0`. Resuming continues from the frozen state.
- `brightness = level` and `phase = state`, both direct register outputs.

## Timing
- Reset values (edge with `nRst=0`, overrides `enable`/`tick`):
  - `state` = UP
  - `level` = 0, `duty` = 0, `pwmCount` = 0, `holdCount` = 0
  - `nLED` = 1, `cycleDone` = 0
  - Reset mid-ramp or mid-hold returns to these values on that same edge.
- Latencies:
  - `tick`→`brightness`/`phase`: visible after the stepping edge, so 1 `clk`.
  - `level`→`duty`: on the next `pwmCount` wrap edge, at most 2^PWM_BITS clocks.
  - `pwmCount`/`duty`→`nLED`: 1 `clk` (registered compare).
- Simultaneous events:
  - A step and a wrap on the same edge: `duty` loads the pre-edge `level`. The new level is applied at the following wrap.
- `cycleDone` is high for exactly the one `clk` after the HOLD_LOW→UP edge.
- Back-to-back ticks on consecutive clocks are legal. Each one is a step.

## Test plan
- Reset: hold `nRst=0` for 3 clocks with `enable=1` and `tick` toggling → `nLED=1`, `brightness=0`, `phase=0`, `cycleDone=0` throughout. After release, `nLED` stays 1 while duty=0.
- Full cycle, with `PWM_BITS=3`, `HOLD_TICKS=2`, one tick every 20 clocks:
  - `brightness` follows 1..7; then `phase` 1 for 2 ticks; then 6..0; then `phase` 3 for 2 ticks.
  - `cycleDone` pulses once at tick 18.
  - Second cycle is identical.
- PWM duty, same params, frozen at level 3 (`tick=0` after 3 steps): after one wrap, `nLED` is 0 for exactly 3 of every 8 clocks, contiguous, starting 1 clk after `pwmCount=0`.
- Glitch-free update: step from level 2 to 3 issued at `pwmCount=4` → the current period still shows 2 low clocks and the next period shows 3.
- Enable freeze: drop `enable` in DOWN at level 5 for 30 clocks with ticks present → `nLED=1`, `brightness` stays 5, `pwmCount` is unchanged. On re-enable, the next tick gives 4.
- Defaults (`PWM_BITS=8`, `HOLD_TICKS=16`): 542 ticks between consecutive `cycleDone` pulses. Level 255 gives exactly 1 off clock per 256.
